nvdla_reset_seq: RTL and testbench

NVDLA_RESET_SEQ -- requirements
Module: nvdla_reset_seq

---
 rtl/nvdla_reset_seq_pkg.sv | 26 ++
 rtl/nv_dft_rst_mux.sv | 15 +
 rtl/nvdla_reset_seq.sv | 136 +++++++++++++
 tb/tb_nvdla_reset_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/nvdla_reset_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nvdla_reset_seq_pkg : shared state type and default timing for the
//                       partition reset sequencer.         Rev 1.0
// ---------------------------------------------------------------------------
package nvdla_reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_PART = 4;
  localparam int DEF_HOLD_CYC = 16;
  localparam int DEF_GAP_CYC  = 8;

  // Counter must span the longer of the two intervals; never narrower than 1 bit.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int m;
    m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nv_dft_rst_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nv_dft_rst_mux : test-mode bypass for one partition reset.  Rev 1.0
// ---------------------------------------------------------------------------
module nv_dft_rst_mux (
  input  logic func_rstn_i,
  input  logic test_rstn_i,
  input  logic test_mode_i,
  output logic rstn_o
);

  assign rstn_o = test_mode_i ? test_rstn_i : func_rstn_i;

endmodule
`default_nettype wire

// File: rtl/nvdla_reset_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nvdla_reset_seq : staggered partition reset release with soft re-sequence
//                   and DFT bypass.                         Rev 1.0
// ---------------------------------------------------------------------------
module nvdla_reset_seq
  import nvdla_reset_seq_pkg::*;
#(
  parameter int NUM_PART = DEF_NUM_PART,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                test_mode,
  input  logic                soft_reset_req,
  output logic [NUM_PART-1:0] part_rstn,
  output logic                seq_done,
  output logic                soft_reset_ack
);

  localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int IDX_W = $clog2(NUM_PART) + 1;

  if (NUM_PART < 1 || NUM_PART > 16) begin : g_bad_num_part
    $error("nvdla_reset_seq: NUM_PART must be in 1..16");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold_cyc
    $error("nvdla_reset_seq: HOLD_CYC must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap_cyc
    $error("nvdla_reset_seq: GAP_CYC must be >= 1");
  end

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [NUM_PART-1:0] part_q,  part_d;
  logic                done_q,  done_d;
  logic                ack_q,   ack_d;
  logic                pend_q,  pend_d;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      part_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    part_d  = part_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    pend_d  = pend_q;

    case (state_q)
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int i = 0; i < NUM_PART; i++) begin
            if (idx_q == IDX_W'(i)) begin
              part_d[i] = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_PART - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
            if (pend_q) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        // The ack cycle is excluded so a requester dropping on ack does not retrigger.
        if (soft_reset_req && !ack_q) begin
          part_d  = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          pend_d  = 1'b1;
          state_d = HOLD;
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_PART; g++) begin : g_dft_mux
    nv_dft_rst_mux u_dft_mux (
      .func_rstn_i (part_q[g]),
      .test_rstn_i (nvdla_core_rstn),
      .test_mode_i (test_mode),
      .rstn_o      (part_rstn[g])
    );
  end

  assign seq_done       = done_q;
  assign soft_reset_ack = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_nvdla_reset_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nvdla_reset_seq : directed self-checking bench for nvdla_reset_seq.
// ---------------------------------------------------------------------------
module tb_nvdla_reset_seq;

  logic       clk;
  logic       rstn;
  logic       test_mode;
  logic       req;
  logic [3:0] part;
  logic       done;
  logic       ack;

  int checks  = 0;
  int errors  = 0;
  int ecnt    = 0;
  int ack_cnt = 0;

  nvdla_reset_seq #(
    .NUM_PART (4),
    .HOLD_CYC (16),
    .GAP_CYC  (8)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .test_mode       (test_mode),
    .soft_reset_req  (req),
    .part_rstn       (part),
    .seq_done        (done),
    .soft_reset_ack  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge n (counted from the last reset release) and sample 1ns later.
  task automatic go(input int n);
    while (ecnt < n) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rstn = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    rstn = 1'b0; test_mode = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_part", 16'(part), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_ack",  16'(ack),  16'h0);

    // Power-on sequence
    release_rst();
    go(23); chk("po_e23", 16'(part), 16'h0);
    go(24); chk("po_e24", 16'(part), 16'h1);
    go(31); chk("po_e31", 16'(part), 16'h1);
    go(32); chk("po_e32", 16'(part), 16'h3);
    go(40); chk("po_e40", 16'(part), 16'h7);
    go(47); chk("po_e47", 16'(part), 16'h7); chk("po_done47", 16'(done), 16'h0);
    go(48); chk("po_e48", 16'(part), 16'hF); chk("po_done48", 16'(done), 16'h1);
    chk("po_ackcnt", 16'(ack_cnt), 16'd0);

    // Soft reset requested at edge 52
    go(52); req = 1'b1;
    go(53); chk("sr_part53", 16'(part), 16'h0); chk("sr_done53", 16'(done), 16'h0);
    go(76); chk("sr_e76", 16'(part), 16'h0);
    go(77); chk("sr_e77", 16'(part), 16'h1);
    go(85); chk("sr_e85", 16'(part), 16'h3);
    go(93); chk("sr_e93", 16'(part), 16'h7);
    go(100); chk("sr_done100", 16'(done), 16'h0); chk("sr_ack100", 16'(ack), 16'h0);
    go(101); chk("sr_e101", 16'(part), 16'hF); chk("sr_done101", 16'(done), 16'h1);
    chk("sr_ack101", 16'(ack), 16'h1);
    req = 1'b0;
    go(102); chk("sr_ack102", 16'(ack), 16'h0); chk("sr_part102", 16'(part), 16'hF);
    chk("sr_ackcnt", 16'(ack_cnt), 16'd1);

    // Reset in RUN, then again mid-RELEASE
    #2 rstn = 1'b0; #1;
    chk("mrun_part", 16'(part), 16'h0); chk("mrun_done", 16'(done), 16'h0);
    release_rst();
    go(36); chk("mrel_e36", 16'(part), 16'h3);
    #2 rstn = 1'b0; #1;
    chk("mrel_part", 16'(part), 16'h0);
    release_rst();
    go(23); chk("rs_e23", 16'(part), 16'h0);
    go(24); chk("rs_e24", 16'(part), 16'h1);

    // Early request during RELEASE
    go(30); req = 1'b1;
    go(32); chk("er_e32", 16'(part), 16'h3);
    go(40); chk("er_e40", 16'(part), 16'h7);
    go(48); chk("er_e48", 16'(part), 16'hF); chk("er_done48", 16'(done), 16'h1);
    chk("er_ack48", 16'(ack), 16'h0);
    go(49); chk("er_e49", 16'(part), 16'h0); chk("er_done49", 16'(done), 16'h0);
    go(72); chk("er_e72", 16'(part), 16'h0);
    go(73); chk("er_e73", 16'(part), 16'h1);
    go(96); chk("er_e96", 16'(part), 16'h7);
    go(97); chk("er_e97", 16'(part), 16'hF); chk("er_ack97", 16'(ack), 16'h1);
    req = 1'b0;
    go(98); chk("er_ack98", 16'(ack), 16'h0);
    chk("er_ackcnt", 16'(ack_cnt), 16'd2);

    // Request held through the ack cycle starts another sequence
    go(100); req = 1'b1;
    go(101); chk("hd_e101", 16'(part), 16'h0);
    go(149); chk("hd_e149", 16'(part), 16'hF); chk("hd_ack149", 16'(ack), 16'h1);
    go(150); chk("hd_e150", 16'(part), 16'hF); chk("hd_ack150", 16'(ack), 16'h0);
    go(151); chk("hd_e151", 16'(part), 16'h0); chk("hd_done151", 16'(done), 16'h0);
    req = 1'b0;

    // Test-mode bypass
    rstn = 1'b0; test_mode = 1'b1; #1;
    chk("tm_rst0", 16'(part), 16'h0);
    release_rst();
    #1; chk("tm_rst1", 16'(part), 16'hF); chk("tm_done0", 16'(done), 16'h0);
    go(10); chk("tm_e10", 16'(part), 16'hF); chk("tm_done10", 16'(done), 16'h0);
    test_mode = 1'b0; #1;
    chk("tm_off", 16'(part), 16'h0);
    go(24); chk("tm_e24", 16'(part), 16'h1);
    go(48); chk("tm_e48", 16'(part), 16'hF); chk("tm_done48", 16'(done), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
